// File: rtl/mlp_seq_ctrl.sv
// Sequencer for a tiny 8-4-3 style MLP: issues five neuron evaluations on a shared
// datapath, stores the results, picks the winning class and hands it to the consumer.
module mlp_seq_ctrl #(
    parameter int DP_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inp,
    output logic        dp_start,
    output logic        dp_layer,
    output logic [1:0]  dp_neuron,
    output logic [31:0] dp_x,
    input  logic        dp_done,
    input  logic [14:0] dp_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out,
    output logic        err,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // out/err never change while out_valid=1 and out_ready=0.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ARGMAX = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_x;
    logic [7:0]  r_h1;
    logic [7:0]  r_h2;
    logic [14:0] r_o0;
    logic [14:0] r_o1;
    logic [14:0] r_o2;
    logic        r_layer;
    logic [1:0]  r_neuron;
    logic [3:0]  r_cnt;
    logic [1:0]  r_out;
    logic        r_err;

    logic        w_last_eval;
    logic        w_timeout;
    logic [1:0]  w_argmax;

    assign w_last_eval = r_layer && (r_neuron == 2'd2);
    // This WAIT cycle is the DP_TIMEOUT-th one without dp_done.
    assign w_timeout   = (({1'b0, r_cnt} + 5'd1) >= 5'(DP_TIMEOUT));

    always_comb begin
        w_argmax = 2'd0;
        if (!((r_o0 >= r_o1) && (r_o0 >= r_o2))) begin
            w_argmax = (r_o1 >= r_o2) ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_x      <= 32'd0;
            r_h1     <= 8'd0;
            r_h2     <= 8'd0;
            r_o0     <= 15'd0;
            r_o1     <= 15'd0;
            r_o2     <= 15'd0;
            r_layer  <= 1'b0;
            r_neuron <= 2'd0;
            r_cnt    <= 4'd0;
            r_out    <= 2'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x      <= inp;
                        r_layer  <= 1'b0;
                        r_neuron <= 2'd1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= 4'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp_done) begin
                        case ({r_layer, r_neuron})
                            3'b001:  r_h1 <= dp_res[7:0];
                            3'b010:  r_h2 <= dp_res[7:0];
                            3'b100:  r_o0 <= dp_res;
                            3'b101:  r_o1 <= dp_res;
                            3'b110:  r_o2 <= dp_res;
                            default: ;
                        endcase
                        if (w_last_eval) begin
                            r_state <= S_ARGMAX;
                        end else begin
                            // Hidden neuron 0 is constant zero, so layer 0 ends after neuron 2.
                            if (!r_layer && (r_neuron == 2'd2)) begin
                                r_layer  <= 1'b1;
                                r_neuron <= 2'd0;
                            end else begin
                                r_neuron <= r_neuron + 2'd1;
                            end
                            r_state <= S_START;
                        end
                    end else if (w_timeout) begin
                        r_out   <= 2'b11;
                        r_err   <= 1'b1;
                        r_state <= S_OUT;
                    end else if (r_cnt != 4'hF) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ARGMAX: begin
                    r_out   <= w_argmax;
                    r_err   <= 1'b0;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign dp_start    = (r_state == S_START);
    assign dp_layer    = r_layer;
    assign dp_neuron   = r_neuron;
    assign dp_x        = r_layer ? {8'd0, r_h2, r_h1, 8'd0} : r_x;
    assign out_valid   = (r_state == S_OUT);
    assign out         = r_out;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Bench for mlp_seq_ctrl: a datapath model answers each dp_start, a scoreboard predicts
// class, error flag and result latency per sample, and a monitor checks the output side.
module tb_mlp_seq_ctrl;

    localparam int TO = 15;

    typedef struct {
        logic [31:0]      x;
        logic [4:0][14:0] res;   // results in issue order (0,1),(0,2),(1,0),(1,1),(1,2)
        int               lat;
        int               wh;    // index of the evaluation whose dp_done is withheld, 5 = none
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inp;
    logic        dp_start;
    logic        dp_layer;
    logic [1:0]  dp_neuron;
    logic [31:0] dp_x;
    logic        dp_done = 1'b0;
    logic [14:0] dp_res = 15'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out;
    logic        err;
    logic [2:0]  dbg_state;

    mlp_seq_ctrl #(.DP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
        .dp_start(dp_start), .dp_layer(dp_layer), .dp_neuron(dp_neuron), .dp_x(dp_x),
        .dp_done(dp_done), .dp_res(dp_res), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .err(err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int hs_cyc   = -10;
    int stall_until = 0;

    cfg_t            cfg_q[$];
    logic [2:0]      exp_q[$];
    int              lat_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: class = first index of the largest output score, or 3 with err on timeout.
    function automatic logic [2:0] ref_resp(input cfg_t c);
        int best;
        if (c.wh < 5) return 3'b111;
        best = 0;
        for (int i = 1; i < 3; i++) begin
            if (c.res[2+i] > c.res[2+best]) best = i;
        end
        return {1'b0, 2'(best)};
    endfunction

    // Cycles from capture to the first out_valid cycle.
    function automatic int ref_lat(input cfg_t c);
        if (c.wh < 5) return 1 + c.wh * (c.lat + 1) + TO + 1;
        return 5 * (c.lat + 1) + 2;
    endfunction

    function automatic cfg_t mk(input logic [31:0] x, input logic [14:0] r0, input logic [14:0] r1,
                                input logic [14:0] r2, input logic [14:0] r3, input logic [14:0] r4,
                                input int lat, input int wh);
        cfg_t c;
        c.x = x;
        c.res[0] = r0; c.res[1] = r1; c.res[2] = r2; c.res[3] = r3; c.res[4] = r4;
        c.lat = lat;
        c.wh = wh;
        return c;
    endfunction

    // out_ready: mostly high, forced low up to stall_until.
    always @(posedge clk) begin
        #2;
        if (cyc < stall_until) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 3) != 0);
    end

    // Datapath model.
    int         ev = 0;
    bit         pend = 0;
    int         pcnt = 0;
    logic [14:0] pres = 15'd0;
    bit         chk_on = 0;
    logic [34:0] exp_dp = 35'd0;
    cfg_t       cur;

    always @(negedge clk) begin
        dp_done = 1'b0;
        if (rst_n && chk_on && !dp_start)
            chk("dp_operands_stable", 64'({dp_layer, dp_neuron, dp_x}), 64'(exp_dp));
        if (pend) begin
            if (pcnt <= 1) begin
                dp_done = 1'b1;
                dp_res  = pres;
                pend    = 0;
                chk_on  = 0;
            end else begin
                pcnt--;
            end
        end
        if (!rst_n) begin
            ev = 0;
            chk_on = 0;
        end else begin
            if (out_valid) chk_on = 0;
            if (dp_start) begin
                if (ev == 0 && cfg_q.size() == 0) begin
                    flag("spurious_dp_start");
                end else begin
                    if (ev == 0) cur = cfg_q.pop_front();
                    exp_dp[34:32] = (ev < 2) ? {1'b0, 2'(ev + 1)} : {1'b1, 2'(ev - 2)};
                    exp_dp[31:0]  = (ev < 2) ? cur.x : {8'd0, cur.res[1][7:0], cur.res[0][7:0], 8'd0};
                    chk("dp_issue", 64'({dp_layer, dp_neuron, dp_x}), 64'(exp_dp));
                    chk_on = 1;
                    if (ev != cur.wh) begin
                        pend = 1;
                        pcnt = cur.lat;
                        pres = cur.res[ev];
                    end
                    if (ev == cur.wh || ev == 4) ev = 0;
                    else ev++;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    bit         prev_v = 0;
    bit         prev_r = 0;
    logic [2:0] prev_resp = 3'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
            prev_r = 0;
        end else begin
            if (out_valid) begin
                chk("busy_in_ready", 64'(in_ready), 64'd0);
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_out_valid");
                    end else begin
                        chk("result", 64'({err, out}), 64'(exp_q.pop_front()));
                        chk("latency", 64'(cyc), 64'(lat_q.pop_front()));
                    end
                end else if (!prev_r) begin
                    chk("out_hold_stable", 64'({err, out}), 64'(prev_resp));
                end
                prev_resp = {err, out};
                if (out_ready) hs_cyc = cyc;
            end
            prev_v = out_valid;
            prev_r = out_ready;
        end
    end

    task automatic check_reset_vals(input string name);
        chk(name, 64'({in_ready, dp_start, out_valid, err, out, dp_layer, dp_neuron, dp_x}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0}));
    endtask

    // Called at a falling edge; returns at the falling edge after the capture edge.
    task automatic send(input cfg_t c);
        int n;
        bit waited;
        in_valid = 1'b1;
        inp = c.x;
        n = 0;
        waited = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
            waited = 1;
        end
        if (!in_ready) begin
            flag("capture_timeout");
            in_valid = 1'b0;
            return;
        end
        cfg_q.push_back(c);
        exp_q.push_back(ref_resp(c));
        lat_q.push_back(cyc + ref_lat(c));
        if (waited) chk("capture_after_handshake", 64'(cyc), 64'(hs_cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
        inp = $urandom();
    endtask

    function automatic logic [14:0] rnd_o(input bit tie);
        logic [14:0] v;
        if (tie) begin
            case ($urandom_range(0, 2))
                0:       v = 15'd0;
                1:       v = 15'd7;
                default: v = 15'h7FFF;
            endcase
        end else begin
            v = 15'($urandom_range(0, 32767));
        end
        return v;
    endfunction

    initial begin
        cfg_t c;
        int n;
        bit tie;
        rst_n = 1'b0;
        in_valid = 1'b0;
        inp = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_initial");
        #1 rst_n = 1'b1;
        @(negedge clk);

        send(mk(32'h0000_0000, 15'd0, 15'd128, 15'd0, 15'd0, 15'd0, 1, 5));
        send(mk(32'h1234_5678, 15'h00A5, 15'h003C, 15'd100, 15'd300, 15'd300, 2, 5));
        send(mk(32'hFEDC_BA98, 15'h7FA5, 15'h413C, 15'd0, 15'd0, 15'd0, 3, 5));
        send(mk(32'h8765_4321, 15'd5, 15'd6, 15'd7, 15'd8, 15'd9, 1, 3));
        send(mk(32'h0F0F_0F0F, 15'd11, 15'd22, 15'd500, 15'd400, 15'd600, 1, 5));

        // Consumer stalls through the whole OUT phase while the next sample waits.
        stall_until = cyc + 45;
        send(mk(32'hCAFE_F00D, 15'd1, 15'd2, 15'd9, 15'd3, 15'd2, 1, 5));
        send(mk(32'h1111_2222, 15'd3, 15'd4, 15'd5, 15'd6, 15'd6, 2, 5));

        // Reset while waiting on (0,2); its dp_done arrives after release.
        send(mk(32'hABCD_EF01, 15'd77, 15'd88, 15'd1, 15'd2, 15'd3, 4, 5));
        n = 0;
        while (!(dp_layer == 1'b0 && dp_neuron == 2'd2 && !dp_start) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) flag("reach_wait_0_2");
        #1 rst_n = 1'b0;
        cfg_q.delete();
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check_reset_vals("reset_mid_eval");
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_reset_vals("after_late_done");
        send(mk(32'h5555_AAAA, 15'd9, 15'd8, 15'd30, 15'd31, 15'd29, 1, 5));

        for (int i = 0; i < 30; i++) begin
            tie = ($urandom_range(0, 3) == 0);
            c = mk($urandom(), 15'($urandom_range(0, 32767)), 15'($urandom_range(0, 32767)),
                   rnd_o(tie), rnd_o(tie), rnd_o(tie), $urandom_range(1, 4),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : 5);
            send(c);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) flag("drain_timeout");
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
